// File: rtl/adc_capture.sv
// Serial ADC sample capture: a 3-state shift FSM pushes completed words into a small circular FIFO.
// Overflow is a sticky flag. short_frame pulses for one cycle when a frame ends mid-word.
module adc_capture #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame,
    input  logic                     data_en,
    input  logic                     sdi,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     short_frame,
    input  logic                     clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W:0]     shifted;
    logic [DATA_W-1:0]   first_word;
    logic                push;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic                full;
    logic                pop;
    logic                accept;

    // For DATA_W == 1 the IDLE sample is already a complete word, so both paths share shifted.
    always_comb begin
        shifted    = {shreg, sdi};
        first_word = '0;
        first_word[0] = sdi;
        push       = 1'b0;
        case (state)
            IDLE:    push = frame && data_en && (DATA_W == 1);
            SHIFT:   push = frame && data_en && (cnt == CW'(DATA_W - 1));
            default: push = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            short_frame <= 1'b0;
        end else begin
            short_frame <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame && data_en) begin
                        shreg <= first_word;
                        cnt   <= CW'(1);
                        state <= (DATA_W == 1) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (!frame) begin
                        short_frame <= 1'b1;
                        shreg       <= '0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else if (data_en) begin
                        shreg <= shifted[DATA_W-1:0];
                        cnt   <= cnt + CW'(1);
                        if (push)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (!frame) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full      = (level == (AW+1)'(DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign accept    = push && (!full || pop);
    assign out_data  = out_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr] <= shifted[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({accept, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            overflow <= (push && full && !pop) || (overflow && !clr_flags);
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: frame-level vector table plus hand sequences for
// latency, overflow/clear interplay, full push+pop and mid-frame reset.
module tb_adc_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame;
    logic        data_en;
    logic        sdi;
    logic [9:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;
    logic        short_frame;
    logic        clr_flags;

    int n_tests = 0;
    int n_fail  = 0;
    int sf_hi   = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          stall_at;
        int          stall_len;
        int          exp_sf;
        int          exp_level;
        logic        exp_ovf;
        logic [9:0]  exp_head;
    } vec_t;

    vec_t vecs[5];

    adc_capture #(.DATA_W(10), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame       (frame),
        .data_en     (data_en),
        .sdi         (sdi),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow),
        .short_frame (short_frame),
        .clr_flags   (clr_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (short_frame === 1'b1)
            sf_hi++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [15:0] bits, input int nbits, input int stall_at,
                              input int stall_len, input bit pop_last, input bit clr_last);
        for (int i = 0; i < nbits; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    frame = 1'b1; data_en = 1'b0;
                end
            end
            @(negedge clk);
            frame     = 1'b1;
            data_en   = 1'b1;
            sdi       = bits[nbits-1-i];
            out_ready = pop_last && (i == nbits - 1);
            clr_flags = clr_last && (i == nbits - 1);
        end
        @(negedge clk);
        frame = 1'b0; data_en = 1'b0; sdi = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            check($sformatf("%s_d%0d", tag, k), {22'b0, out_data}, {22'b0, exp_q.pop_front()});
            out_ready = 1'b1;
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int sf0;
        logic [9:0] w;

        vecs[0] = '{bits:16'h0155, nbits:10, stall_at:4,  stall_len:3, exp_sf:0, exp_level:2, exp_ovf:1'b0, exp_head:10'h2A5};
        vecs[1] = '{bits:16'h002D, nbits:6,  stall_at:-1, stall_len:0, exp_sf:1, exp_level:2, exp_ovf:1'b0, exp_head:10'h2A5};
        vecs[2] = '{bits:16'h03FF, nbits:10, stall_at:-1, stall_len:0, exp_sf:0, exp_level:3, exp_ovf:1'b0, exp_head:10'h2A5};
        vecs[3] = '{bits:16'h0001, nbits:10, stall_at:-1, stall_len:0, exp_sf:0, exp_level:4, exp_ovf:1'b0, exp_head:10'h2A5};
        vecs[4] = '{bits:16'h0002, nbits:10, stall_at:-1, stall_len:0, exp_sf:0, exp_level:4, exp_ovf:1'b1, exp_head:10'h2A5};

        reset = 1'b0; frame = 1'b0; data_en = 1'b0; sdi = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_level", {29'b0, level}, 0);
        check("rst_data",  {22'b0, out_data}, 0);
        check("rst_ovf",   {31'b0, overflow}, 0);
        check("rst_sf",    {31'b0, short_frame}, 0);
        reset = 1'b1;
        @(negedge clk);

        // First word with explicit latency check around the 10th bit.
        w   = 10'h2A5;
        sf0 = sf_hi;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 9)
                check("lat_pre_valid", {31'b0, out_valid}, 0);
            frame = 1'b1; data_en = 1'b1; sdi = w[9-i];
        end
        @(negedge clk);
        check("lat_valid", {31'b0, out_valid}, 1);
        check("lat_data",  {22'b0, out_data}, 32'h2A5);
        check("lat_level", {29'b0, level}, 1);
        frame = 1'b0; data_en = 1'b0;
        repeat (2) @(negedge clk);
        check("lat_sf", sf_hi - sf0, 0);

        for (int i = 0; i < 5; i++) begin
            sf0 = sf_hi;
            send_frame(vecs[i].bits, vecs[i].nbits, vecs[i].stall_at, vecs[i].stall_len, 1'b0, 1'b0);
            check($sformatf("v%0d_sf", i),    sf_hi - sf0, vecs[i].exp_sf);
            check($sformatf("v%0d_level", i), {29'b0, level}, vecs[i].exp_level);
            check($sformatf("v%0d_ovf", i),   {31'b0, overflow}, {31'b0, vecs[i].exp_ovf});
            check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 1);
            check($sformatf("v%0d_head", i),  {22'b0, out_data}, {22'b0, vecs[i].exp_head});
        end

        exp_q = '{10'h2A5, 10'h155, 10'h3FF, 10'h001};
        drain("ovf");
        check("empty_level", {29'b0, level}, 0);
        check("empty_valid", {31'b0, out_valid}, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("pop_empty_level", {29'b0, level}, 0);
        check("pop_empty_data",  {22'b0, out_data}, 0);
        check("ovf_sticky", {31'b0, overflow}, 1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("ovf_cleared", {31'b0, overflow}, 0);

        // Fill, then overflow in the same cycle as clr_flags, then push while popping at full.
        for (int i = 1; i <= 4; i++)
            send_frame(16'(i), 10, -1, 0, 1'b0, 1'b0);
        check("full_level", {29'b0, level}, 4);
        check("full_ovf",   {31'b0, overflow}, 0);
        send_frame(16'h00AA, 10, -1, 0, 1'b0, 1'b1);
        check("clr_vs_ovf", {31'b0, overflow}, 1);
        check("clr_vs_ovf_level", {29'b0, level}, 4);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("clr_alone", {31'b0, overflow}, 0);
        send_frame(16'h0005, 10, -1, 0, 1'b1, 1'b0);
        check("pushpop_level", {29'b0, level}, 4);
        check("pushpop_ovf",   {31'b0, overflow}, 0);
        exp_q = '{10'h002, 10'h003, 10'h004, 10'h005};
        drain("pushpop");
        check("pushpop_empty", {29'b0, level}, 0);

        // Reset in the middle of a frame with two words queued.
        send_frame(16'h0011, 10, -1, 0, 1'b0, 1'b0);
        send_frame(16'h0022, 10, -1, 0, 1'b0, 1'b0);
        check("pre_rst_level", {29'b0, level}, 2);
        w = 10'h3C3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            frame = 1'b1; data_en = 1'b1; sdi = w[9-i];
        end
        #2 reset = 1'b0;
        #1;
        check("midrst_level", {29'b0, level}, 0);
        check("midrst_valid", {31'b0, out_valid}, 0);
        check("midrst_data",  {22'b0, out_data}, 0);
        @(negedge clk);
        frame = 1'b0; data_en = 1'b0; sdi = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sf0 = sf_hi;
        send_frame({4'b0, 10'h1C3, 2'b10}, 12, -1, 0, 1'b0, 1'b0);
        check("postrst_level", {29'b0, level}, 1);
        check("postrst_data",  {22'b0, out_data}, 32'h1C3);
        check("postrst_sf",    sf_hi - sf0, 0);
        @(negedge clk);
        check("postrst_level2", {29'b0, level}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
